ahb2apb_bridge_v2: RTL and testbench

Single-clock AHB-Lite slave to APB4 master bridge. It is the parametrised successor of the first-generation bridge, adding:
- registered APB setup/access phases
- pclken-gated APB timing
- write-data capture
- slot decode with error on unmapped slots
- PSLVERR propagation as a two-cycle AHB ERROR response
- an optional access timeout

Sits between the AHB interconnect and up to PSLV_NUM APB peripherals (UART, SPI, I2C, memory, LED, ...).

---
 rtl/ahb_apb_pkg.sv | 35 +++
 rtl/apb_rsp_mux.sv | 35 +++
 rtl/ahb2apb_bridge_v2.sv | 188 ++++++++++++++++++
 tb/tb_ahb2apb_bridge_v2.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ahb_apb_pkg : shared state encoding and AHB constants for the bridge
// Rev 1.0
// ------------------------------------------------------------------
package ahb_apb_pkg;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_data   = 3'd1;
  localparam logic [2:0] c_st_wait   = 3'd2;
  localparam logic [2:0] c_st_setup  = 3'd3;
  localparam logic [2:0] c_st_access = 3'd4;
  localparam logic [2:0] c_st_err1   = 3'd5;
  localparam logic [2:0] c_st_err2   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = c_st_idle,
    S_DATA   = c_st_data,
    S_WAIT   = c_st_wait,
    S_SETUP  = c_st_setup,
    S_ACCESS = c_st_access,
    S_ERR1   = c_st_err1,
    S_ERR2   = c_st_err2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/apb_rsp_mux.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_rsp_mux : selects one slave's pready/pslverr/prdata by slot index
// Rev 1.0
// ------------------------------------------------------------------
module apb_rsp_mux #(
  parameter int PSLV_NUM   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [SEL_WIDTH-1:0]           i_slot,
  input  logic [PSLV_NUM-1:0]            i_pready,
  input  logic [PSLV_NUM-1:0]            i_pslverr,
  input  logic [PSLV_NUM*DATA_WIDTH-1:0] i_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [DATA_WIDTH-1:0]          o_prdata
);

  // An index with no matching slave leaves all outputs at zero.
  always_comb begin
    o_pready  = 1'b0;
    o_pslverr = 1'b0;
    o_prdata  = '0;
    for (int k = 0; k < PSLV_NUM; k++) begin
      if (i_slot == SEL_WIDTH'(k)) begin
        o_pready  = i_pready[k];
        o_pslverr = i_pslverr[k];
        o_prdata  = i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb2apb_bridge_v2.sv
`default_nettype none
// ------------------------------------------------------------------
// ahb2apb_bridge_v2 : AHB-Lite slave to APB4 master bridge
// Rev 1.0
// ------------------------------------------------------------------
module ahb2apb_bridge_v2
  import ahb_apb_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int PSLV_NUM    = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [HADDR_WIDTH-1:0]         haddr,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hsize,
  input  logic                           hwrite,
  input  logic [DATA_WIDTH-1:0]          hwdata,
  input  logic [DATA_WIDTH/8-1:0]        hwstrb,
  input  logic                           hsel_i,
  input  logic                           hready_i,
  output logic                           hready_o,
  output logic                           hresp_o,
  output logic [DATA_WIDTH-1:0]          hrdata_o,
  input  logic                           pclken,
  output logic [PADDR_WIDTH-1:0]         paddr,
  output logic [PSLV_NUM-1:0]            psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [PSLV_NUM-1:0]            pready_i,
  input  logic [PSLV_NUM-1:0]            pslverr_i,
  input  logic [PSLV_NUM*DATA_WIDTH-1:0] prdata_i
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_WIDTH:0] c_pslv_num = (SEL_WIDTH+1)'(PSLV_NUM);

  state_t                 r_state;
  logic [PADDR_WIDTH-1:0] r_addr;
  logic [SEL_WIDTH-1:0]   r_slot;
  logic                   r_write;
  logic [c_cnt_w-1:0]     r_cnt;

  logic                  w_xfer_req;
  logic                  w_accept;
  logic                  w_dec_err;
  logic                  w_timeout;
  logic [PSLV_NUM-1:0]   w_psel_dec;
  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_unused;

  assign w_xfer_req = hsel_i & hready_i & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign w_accept   = w_xfer_req & ((r_state == S_IDLE) | (r_state == S_ERR2));
  assign w_dec_err  = ({1'b0, r_slot} >= c_pslv_num);

  assign hready_o = (r_state == S_IDLE) | (r_state == S_ERR2);
  assign hresp_o  = ((r_state == S_ERR1) | (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    w_psel_dec = '0;
    for (int k = 0; k < PSLV_NUM; k++) begin
      w_psel_dec[k] = (r_slot == SEL_WIDTH'(k));
    end
  end

  apb_rsp_mux #(
    .PSLV_NUM   (PSLV_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_rsp_mux (
    .i_slot    (r_slot),
    .i_pready  (pready_i),
    .i_pslverr (pslverr_i),
    .i_prdata  (prdata_i),
    .o_pready  (w_pready),
    .o_pslverr (w_pslverr),
    .o_prdata  (w_prdata)
  );

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // Address bits above the slot field and hsize carry no meaning for APB.
  generate
    if (HADDR_WIDTH > PADDR_WIDTH + SEL_WIDTH) begin : g_haddr_hi
      assign w_unused = ^{hsize, haddr[HADDR_WIDTH-1:PADDR_WIDTH+SEL_WIDTH]};
    end else begin : g_haddr_exact
      assign w_unused = ^hsize;
    end
  endgenerate

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_slot   <= '0;
      r_write  <= 1'b0;
      r_cnt    <= '0;
      hrdata_o <= '0;
      paddr    <= '0;
      psel     <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pstrb    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_accept) begin
            r_addr  <= haddr[PADDR_WIDTH-1:0];
            r_slot  <= haddr[PADDR_WIDTH+SEL_WIDTH-1:PADDR_WIDTH];
            r_write <= hwrite;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          pwdata <= hwdata;
          pstrb  <= r_write ? hwstrb : '0;
          if (w_dec_err) begin
            r_state <= S_ERR1;
          end else if (pclken) begin
            paddr   <= r_addr;
            pwrite  <= r_write;
            psel    <= w_psel_dec;
            penable <= 1'b0;
            r_state <= S_SETUP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pclken) begin
            paddr   <= r_addr;
            pwrite  <= r_write;
            psel    <= w_psel_dec;
            penable <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (pclken) begin
            penable <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (pclken) begin
            if (w_pready) begin
              psel    <= '0;
              penable <= 1'b0;
              // Read data is only returned on a clean completion.
              if (!r_write && !w_pslverr) begin
                hrdata_o <= w_prdata;
              end
              r_state <= w_pslverr ? S_ERR1 : S_IDLE;
            end else if (w_timeout) begin
              psel    <= '0;
              penable <= 1'b0;
              r_state <= S_ERR1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_ERR1: r_state <= S_ERR2;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge_v2.sv
`default_nettype none
// tb_ahb2apb_bridge_v2 : directed table plus randomized transfers checked
// against a transaction-level model of the bridge.
module tb_ahb2apb_bridge_v2;
  import ahb_apb_pkg::*;

  localparam int NS = 5;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            hclk = 1'b0;
  logic            hresetn = 1'b0;
  logic [31:0]     haddr = '0;
  logic [1:0]      htrans = HTRANS_IDLE;
  logic [2:0]      hsize = 3'b010;
  logic            hwrite = 1'b0;
  logic [31:0]     hwdata = '0;
  logic [3:0]      hwstrb = '0;
  logic            hsel_i = 1'b0;
  logic            hready_i;
  logic            hready_o, hresp_o;
  logic [31:0]     hrdata_o;
  logic            pclken = 1'b1;
  logic [15:0]     paddr;
  logic [NS-1:0]   psel;
  logic            penable, pwrite;
  logic [31:0]     pwdata;
  logic [3:0]      pstrb;
  logic [NS-1:0]   pready_i, pslverr_i;
  logic [NS*DW-1:0] prdata_i;

  assign hready_i = hready_o;
  always #5 hclk = ~hclk;

  ahb2apb_bridge_v2 #(.TIMEOUT(TO)) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hwstrb(hwstrb), .hsel_i(hsel_i), .hready_i(hready_i),
    .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o), .pclken(pclken),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  // Slave side: the addressed slave inserts cfg_wait not-ready ACCESS ticks.
  int          cfg_slot = 0;
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          acc_ticks = 0;
  int          pc_div = 1;
  int          pc_cnt = 0;
  logic        pclk_s = 1'b1;

  always @(negedge hclk) begin
    pc_cnt = (pc_cnt + 1 >= pc_div) ? 0 : pc_cnt + 1;
    pclken = (pc_cnt == 0);
  end

  always @(posedge hclk) begin
    pclk_s <= pclken;
    if (psel == '0) acc_ticks <= 0;
    else if (pclken && penable && acc_ticks < cfg_wait) acc_ticks <= acc_ticks + 1;
  end

  always_comb begin
    pready_i  = '0;
    pslverr_i = '0;
    prdata_i  = {NS{~cfg_rdata}};
    for (int k = 0; k < NS; k++) begin
      if (k == cfg_slot) begin
        prdata_i[k*DW +: DW] = cfg_rdata;
        if (acc_ticks >= cfg_wait) begin
          pready_i[k]  = 1'b1;
          pslverr_i[k] = cfg_err;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: response, read data and (pclken=1) latency.
  function automatic void ref_model(input int slot, input logic wr, input int nwait,
      input logic serr, input logic [31:0] rd, input int div, input logic [31:0] last,
      output logic err, output logic [31:0] rdat, output int lat);
    bit dec;
    bit tmo;
    int ticks;
    dec   = (slot >= NS);
    tmo   = !dec && (TO != 0) && (nwait >= TO);
    err   = dec || tmo || serr;
    rdat  = (!err && !wr) ? rd : last;
    ticks = tmo ? TO : nwait + 1;
    if (div != 1) lat = 0;
    else if (dec) lat = 3;
    else lat = 2 + ticks + (err ? 2 : 1);
  endfunction

  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
      input logic [31:0] wd, input logic [3:0] st, input int nwait, input logic serr,
      input logic [31:0] rd, input int div, input logic exp_err,
      input logic [31:0] exp_rdata, input int exp_lat);
    int slot, cyc, psel_cyc, pen_cyc;
    bit dec;
    logic prev_hresp;
    logic [NS-1:0] s_psel;
    logic [15:0] s_paddr;
    logic s_pwrite;
    logic [31:0] s_pwdata;
    logic [3:0] s_pstrb;
    logic [26:0] p_ctl;
    logic [31:0] p_wdata;
    slot = int'(addr[19:16]);
    dec  = (slot >= NS);
    cfg_slot = slot; cfg_wait = nwait; cfg_err = serr; cfg_rdata = rd; pc_div = div;
    chk({tag, "/addr_ready"}, hready_o, 1'b1);
    hsel_i = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr;
    @(negedge hclk);
    hwdata = wd; hwstrb = st; hsel_i = 1'b0; htrans = HTRANS_IDLE; hwrite = ~wr;
    cyc = 1; psel_cyc = 0; pen_cyc = 0; prev_hresp = 1'b0;
    p_ctl = '0; p_wdata = '0;
    s_psel = '0; s_paddr = '0; s_pwrite = 1'b0; s_pwdata = '0; s_pstrb = '0;
    forever begin
      // With pclken low at the last edge, an active APB phase must not move.
      if (p_ctl[26:22] != '0 && !pclk_s) begin
        chk({tag, "/freeze_ctl"}, {5'd0, psel, penable, pwrite, pstrb, paddr}, {5'd0, p_ctl});
        chk({tag, "/freeze_wdata"}, pwdata, p_wdata);
      end
      if (psel != '0 && psel_cyc == 0) begin
        psel_cyc = cyc; s_psel = psel; s_paddr = paddr; s_pwrite = pwrite;
        s_pwdata = pwdata; s_pstrb = pstrb;
      end
      if (penable && pen_cyc == 0) pen_cyc = cyc;
      if (hready_o || cyc >= 300) break;
      prev_hresp = hresp_o;
      p_ctl = {psel, penable, pwrite, pstrb, paddr};
      p_wdata = pwdata;
      @(negedge hclk);
      cyc++;
    end
    chk({tag, "/done"}, hready_o, 1'b1);
    chk({tag, "/hresp"}, hresp_o, exp_err);
    if (exp_err) chk({tag, "/err1_hresp"}, prev_hresp, 1'b1);
    chk({tag, "/hrdata"}, hrdata_o, exp_rdata);
    chk({tag, "/psel_clear"}, {psel, penable}, '0);
    if (exp_lat > 0) chk({tag, "/latency"}, cyc, exp_lat);
    if (dec) begin
      chk({tag, "/no_psel"}, psel_cyc, 0);
    end else begin
      chk({tag, "/psel"}, s_psel, 1 << slot);
      chk({tag, "/paddr"}, s_paddr, addr[15:0]);
      chk({tag, "/pwrite"}, s_pwrite, wr);
      chk({tag, "/pwdata"}, s_pwdata, wd);
      chk({tag, "/pstrb"}, s_pstrb, wr ? st : 4'h0);
      if (div == 1) begin
        chk({tag, "/psel_cycle"}, psel_cyc, 2);
        chk({tag, "/penable_cycle"}, pen_cyc, 3);
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          nwait;
    logic        serr;
    logic [31:0] rd;
    int          div;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk_reset_values(input string tag);
    chk({tag, "/hready"}, hready_o, 1'b1);
    chk({tag, "/hresp"}, hresp_o, 1'b0);
    chk({tag, "/hrdata"}, hrdata_o, '0);
    chk({tag, "/psel_penable"}, {psel, penable}, '0);
    chk({tag, "/paddr"}, paddr, '0);
    chk({tag, "/pwrite"}, pwrite, 1'b0);
    chk({tag, "/pwdata"}, pwdata, '0);
    chk({tag, "/pstrb"}, pstrb, '0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before 600000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last, rdx, addr;
    logic e;
    int lat, slot, cyc;
    tbl[0] = '{32'h4001_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, 0,   1'b0, 32'h0,         1, 1'b0, 32'h0,         4};
    tbl[1] = '{32'h4003_0004, 1'b0, 32'h0,         4'hF, 2,   1'b0, 32'h1234_5678, 4, 1'b0, 32'h1234_5678, 0};
    tbl[2] = '{32'h4007_0000, 1'b0, 32'h0,         4'h0, 0,   1'b0, 32'h5555_0000, 1, 1'b1, 32'h1234_5678, 3};
    tbl[3] = '{32'h4002_0008, 1'b0, 32'h0,         4'h0, 0,   1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'h1234_5678, 5};
    tbl[4] = '{32'h4000_0020, 1'b1, 32'h1122_3344, 4'h3, 100, 1'b0, 32'h0,         1, 1'b1, 32'h1234_5678, 8};
    tbl[5] = '{32'h4004_00FC, 1'b0, 32'h0,         4'h0, 1,   1'b0, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D, 0};
    tbl[6] = '{32'h400F_0000, 1'b1, 32'h9999_0000, 4'hF, 0,   1'b0, 32'h0,         1, 1'b1, 32'hCAFE_F00D, 3};
    tbl[7] = '{32'h4000_0040, 1'b0, 32'h0,         4'h0, 3,   1'b0, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D, 7};

    hresetn = 1'b0;
    repeat (3) @(negedge hclk);
    chk_reset_values("reset");
    hresetn = 1'b1;
    @(negedge hclk);

    for (int i = 0; i < 8; i++) begin
      do_xfer($sformatf("t%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].st,
              tbl[i].nwait, tbl[i].serr, tbl[i].rd, tbl[i].div,
              tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat);
    end
    last = tbl[7].exp_rdata;

    for (int n = 0; n < 40; n++) begin
      logic wr, serr;
      logic [31:0] wd, rd;
      logic [3:0] st;
      int nwait, div;
      slot  = $urandom_range(0, 7);
      wr    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      rd    = $urandom;
      st    = 4'($urandom);
      nwait = $urandom_range(0, 5);
      serr  = ($urandom_range(0, 3) == 0);
      div   = $urandom_range(1, 3);
      addr  = 32'h4000_0000 | (32'(slot) << 16) | ($urandom & 32'h0000_FFFF);
      if ($urandom_range(0, 2) == 0) begin
        hsel_i = 1'b1;
        htrans = ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
        @(negedge hclk);
        chk($sformatf("r%0d/idle_ignored", n), {hready_o, hresp_o}, 2'b10);
        hsel_i = 1'b0;
        htrans = HTRANS_IDLE;
      end
      ref_model(slot, wr, nwait, serr, rd, div, last, e, rdx, lat);
      do_xfer($sformatf("r%0d", n), addr, wr, wd, st, nwait, serr, rd, div, e, rdx, lat);
      last = rdx;
    end

    // Read, back-to-back write, then a read cut short by reset in ACCESS.
    do_xfer("b2b_rd", 32'h4001_0100, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA, 1,
            1'b0, 32'h5555_AAAA, 4);
    do_xfer("b2b_wr", 32'h4003_0200, 1'b1, 32'h3C3C_C3C3, 4'hA, 0, 1'b0, 32'h0, 1,
            1'b0, 32'h5555_AAAA, 4);
    cfg_slot = 2; cfg_wait = 100; cfg_err = 1'b0; cfg_rdata = 32'h7777_8888; pc_div = 3;
    hsel_i = 1'b1; htrans = HTRANS_SEQ; haddr = 32'h4002_0030; hwrite = 1'b0;
    @(negedge hclk);
    hsel_i = 1'b0; htrans = HTRANS_IDLE;
    cyc = 0;
    while (!(penable && psel != '0) && cyc < 50) begin
      @(negedge hclk);
      cyc++;
    end
    chk("rst/reached_access", {psel, penable}, {5'b00100, 1'b1});
    #2 hresetn = 1'b0;
    #1 chk_reset_values("rst_async");
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    do_xfer("post_rst", 32'h4004_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h9999_AAAA, 1,
            1'b0, 32'h9999_AAAA, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
